// File: rtl/j1_io_responder.sv
// j1_io_responder: J1 core I/O block with GPIO, a 16-bit cycle counter and a FIFO-fed 8N1 UART transmitter
module j1_io_responder #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [WIDTH-1:0] io_ptr,
  input  logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_in,
  input  logic [7:0]       gpio_in,
  output logic [7:0]       gpio_out,
  output logic             uart_tx
);
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [WIDTH-1:0] A_GPO = WIDTH'(16'h4000);
  localparam logic [WIDTH-1:0] A_GPI = WIDTH'(16'h4001);
  localparam logic [WIDTH-1:0] A_UDT = WIDTH'(16'h4002);
  localparam logic [WIDTH-1:0] A_UST = WIDTH'(16'h4003);
  localparam logic [WIDTH-1:0] A_CYC = WIDTH'(16'h4004);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [15:0] r_cycle, r_baud;
  logic [2:0] r_idx;
  logic [7:0] r_shift, w_status;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  logic r_ovf, w_full, w_empty, w_push, w_pop, w_baud_done, w_uart_wr, w_status_rd, w_tx;
  logic w_unused;
  assign w_unused = ^io_out[WIDTH-1:8];
  always_comb begin
    w_full = r_count == (AW+1)'(DEPTH);
    w_empty = r_count == '0;
    w_baud_done = r_baud == 16'(CLKS_PER_BIT - 1);
    w_uart_wr = io_we && io_ptr == A_UDT;
    w_status_rd = io_re && io_ptr == A_UST;
    w_push = w_uart_wr && !w_full;
    w_status = {4'(r_count), r_ovf, r_state != IDLE, w_empty, w_full};
    io_in = io_ptr == A_GPO ? WIDTH'(gpio_out) :
            io_ptr == A_GPI ? WIDTH'(gpio_in) :
            io_ptr == A_UST ? WIDTH'(w_status) :
            io_ptr == A_CYC ? WIDTH'(r_cycle) : '0;
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // STOP chains straight into START when more bytes are queued, so frames stay gapless
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_empty ? IDLE : START;
      START:   w_next = w_baud_done ? DATA : START;
      DATA:    w_next = (w_baud_done && r_idx == 3'd7) ? STOP : DATA;
      default: w_next = w_baud_done ? (w_empty ? IDLE : START) : STOP;
    endcase
  end
  always_comb begin
    w_pop = w_next == START && (r_state == IDLE || r_state == STOP);
    w_tx = w_pop ? 1'b0 :
           (r_state == START && w_baud_done) ? r_shift[0] :
           (r_state == DATA && w_baud_done) ? (r_idx == 3'd7 ? 1'b1 : r_shift[1]) : uart_tx;
  end
  always_ff @(posedge clk)
    if (w_push && !rst) r_mem[r_wr] <= io_out[7:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      r_cycle <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
      r_baud <= '0;
      r_idx <= '0;
      r_shift <= '0;
      uart_tx <= 1'b1;
    end else begin
      r_cycle <= r_cycle + 16'd1;
      if (io_we && io_ptr == A_GPO) gpio_out <= io_out[7:0];
      if (w_push) r_wr <= r_wr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf <= (w_uart_wr && w_full) || (r_ovf && !w_status_rd);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_shift <= w_pop ? r_mem[r_rd] : (r_state == DATA && w_baud_done) ? r_shift >> 1 : r_shift;
      r_baud <= (r_state == IDLE || w_baud_done) ? '0 : r_baud + 16'd1;
      r_idx <= (r_state == DATA && w_baud_done) ? r_idx + 3'd1 : r_idx;
      uart_tx <= w_tx;
    end
  end
endmodule

// File: tb/tb_j1_io_responder.sv
// tb_j1_io_responder: directed and random checks of j1_io_responder against a frame-timing reference model
module tb_j1_io_responder;
  localparam int CPB = 4;
  logic clk = 1'b0, rst, io_we, io_re, uart_tx;
  logic [15:0] io_ptr, io_out, io_in, last_rd;
  logic [7:0] gpio_in, gpio_out;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] m_gpio, m_byte;
  logic [15:0] m_cycle;
  logic m_ovf, m_busy;
  int m_t;
  always #5 clk = ~clk;
  j1_io_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .io_we(io_we), .io_re(io_re), .io_ptr(io_ptr), .io_out(io_out),
    .io_in(io_in), .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_tx(uart_tx)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask
  function automatic logic [15:0] m_status();
    return {8'h00, 4'(q.size()), m_ovf, m_busy, q.size() == 0, q.size() == 4};
  endfunction
  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      16'h4000: return {8'h00, m_gpio};
      16'h4001: return {8'h00, gpio_in};
      16'h4003: return m_status();
      16'h4004: return m_cycle;
      default:  return 16'h0000;
    endcase
  endfunction
  // line level from position inside the current 10-bit frame
  function automatic logic m_tx();
    int k;
    k = m_t / CPB;
    if (!m_busy) return 1'b1;
    return k == 0 ? 1'b0 : k <= 8 ? m_byte[k-1] : 1'b1;
  endfunction
  task automatic m_edge(input logic r, input logic we, input logic re, input logic [15:0] p, input logic [15:0] d);
    logic ovf_now;
    if (r) begin
      q.delete();
      m_gpio = 8'h00;
      m_cycle = 16'h0000;
      m_ovf = 1'b0;
      m_busy = 1'b0;
      m_t = 0;
      return;
    end
    m_cycle++;
    ovf_now = we && p == 16'h4002 && q.size() == 4;
    if (we && p == 16'h4000) m_gpio = d[7:0];
    if (m_busy) begin
      m_t++;
      if (m_t == 10 * CPB) m_busy = 1'b0;
    end
    if (!m_busy && q.size() > 0) begin
      m_byte = q.pop_front();
      m_busy = 1'b1;
      m_t = 0;
    end
    if (we && p == 16'h4002 && !ovf_now) q.push_back(d[7:0]);
    m_ovf = ovf_now || (m_ovf && !(re && p == 16'h4003));
  endtask
  task automatic step(input logic r, input logic we, input logic re, input logic [15:0] p, input logic [15:0] d);
    rst = r;
    io_we = we;
    io_re = re;
    io_ptr = p;
    io_out = d;
    gpio_in = 8'($urandom);
    #1;
    last_rd = io_in;
    if (re) chk("io_in", io_in, m_read(p));
    @(posedge clk);
    m_edge(r, we, re, p, d);
    #1;
    chk("uart_tx", {15'h0, uart_tx}, {15'h0, m_tx()});
    chk("gpio_out", {8'h00, gpio_out}, {8'h00, m_gpio});
    rst = 1'b0;
    io_we = 1'b0;
    io_re = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask
  task automatic rd(input logic [15:0] a);
    step(1'b0, 1'b0, 1'b1, a, 16'h0000);
  endtask
  initial begin
    logic [15:0] p;
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h4000, 16'hFFFF);
    rd(16'h4003);
    chk("status_after_reset", last_rd, 16'h0002);
    chk("tx_idle_after_reset", {15'h0, uart_tx}, 16'h0001);
    rd(16'h4004);
    chk("cycle_first", last_rd, 16'h0001);
    wr(16'h4000, 16'h12A5);
    rd(16'h4000);
    chk("gpio_read", last_rd, 16'h00A5);
    chk("gpio_pins", {8'h00, gpio_out}, 16'h00A5);
    wr(16'h4001, 16'h0077);
    wr(16'h4123, 16'h0011);
    rd(16'h4000);
    chk("ro_write_ignored", last_rd, 16'h00A5);
    rd(16'h4002);
    chk("uart_data_reads_zero", last_rd, 16'h0000);
    rd(16'h4005);
    chk("unmapped_reads_zero", last_rd, 16'h0000);
    wr(16'h4002, 16'h0055);
    idle(1);
    chk("tx_start_latency", {15'h0, uart_tx}, 16'h0000);
    idle(39);
    rd(16'h4003);
    chk("busy_before_end", last_rd, 16'h0006);
    rd(16'h4003);
    chk("busy_cleared", last_rd, 16'h0002);
    for (int i = 1; i <= 6; i++) wr(16'h4002, 16'(i));
    rd(16'h4003);
    chk("full_ovf", last_rd, 16'h004D);
    rd(16'h4003);
    chk("ovf_cleared", last_rd, 16'h0045);
    idle(220);
    rd(16'h4003);
    chk("drained", last_rd, 16'h0002);
    for (int i = 0; i < 3; i++) wr(16'h4002, 16'h00C3 + 16'(i));
    idle(50);
    rd(16'h4003);
    chk("frame2_busy", last_rd, 16'h0014);
    step(1'b1, 1'b1, 1'b0, 16'h4002, 16'h00EE);
    chk("tx_high_after_abort", {15'h0, uart_tx}, 16'h0001);
    rd(16'h4003);
    chk("status_after_abort", last_rd, 16'h0002);
    idle(100);
    rd(16'h4003);
    chk("no_frames_after_abort", last_rd, 16'h0002);
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    p = 16'h4002;
        2:       p = 16'h4003;
        3:       p = 16'h4000 + 16'($urandom_range(0, 5));
        4:       p = 16'($urandom);
        default: p = 16'h4004;
      endcase
      step($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, p, 16'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    wr(16'h4000, 16'h003C);
    idle(65535);
    rd(16'h4004);
    chk("cycle_wrap", last_rd, 16'h0000);
    chk("gpio_after_wrap", {8'h00, gpio_out}, 16'h003C);
    rd(16'h4003);
    chk("status_after_wrap", last_rd, 16'h0002);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
